// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes,
// with its own iteration down-counter. The accumulator holds {hi, lo} or {rem, quo}.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              div_mode,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic              cnt_zero,
   output logic [2*XLEN-1:0] acc_next
);

   localparam int CW = $clog2(XLEN);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_q;
   logic [CW-1:0]     cnt;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_sub;
   logic              div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_sub   = div_shift - {1'b0, b_q};
      div_ge    = (div_shift >= {1'b0, b_q});
      acc_next  = {mul_sum, acc[XLEN-1:1]};
      if (div_mode) begin
         // A failed trial subtract keeps the shifted remainder, which is below the divisor and fits XLEN bits.
         acc_next = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
      end
   end

   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         b_q <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= {{XLEN{1'b0}}, a_mag};
         b_q <= b_mag;
         cnt <= CW'(XLEN - 1);
      end else if (step) begin
         acc <= acc_next;
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execution unit: sequencing FSM, sign conversion/fix-up and result registers.
//   state  | meaning
//   IDLE   | waiting for start; decides fast path or iteration
//   MUL    | shift-add iterations, pipeline stalled
//   DIV    | restoring-divide iterations, pipeline stalled
//   DONE   | result_valid_o strobe, instruction advances
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic              accept, busy, fast, b_zero, ovf;
   logic              a_signed, b_signed, sa, sb, neg_nxt;
   logic [XLEN-1:0]   a_mag, b_mag, fast_res, div_word, fix_res;
   logic [2*XLEN-1:0] acc_next, prod;
   logic              cnt_zero;

   assign accept   = (state == S_IDLE) && start_i && !flush_i;
   assign busy     = (state == S_MUL) || (state == S_DIV);
   assign a_signed = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
   assign b_signed = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
   assign sa       = a_signed && op_a_i[XLEN-1];
   assign sb       = b_signed && op_b_i[XLEN-1];
   assign a_mag    = sa ? -op_a_i : op_a_i;
   assign b_mag    = sb ? -op_b_i : op_b_i;
   // Remainder follows the dividend's sign; products and quotients follow the sign difference.
   assign neg_nxt  = (funct3_i[2] && funct3_i[1]) ? sa : (sa ^ sb);

   assign b_zero   = (op_b_i == '0);
   assign ovf      = !funct3_i[0] && (op_a_i == MOST_NEG) && (op_b_i == '1);
   assign fast     = funct3_i[2] && (b_zero || ovf);
   assign fast_res = funct3_i[1] ? (b_zero ? op_a_i : '0) : (b_zero ? '1 : op_a_i);

   assign prod     = neg_q ? -acc_next : acc_next;
   assign div_word = f3_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
   assign fix_res  = f3_q[2] ? (neg_q ? -div_word : div_word)
                   : ((f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && !fast),
      .step     (busy),
      .div_mode (state == S_DIV),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .cnt_zero (cnt_zero),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               stall_o   = 1'b1;
               state_nxt = fast ? S_DONE : (funct3_i[2] ? S_DIV : S_MUL);
            end
         end
         S_MUL, S_DIV: begin
            stall_o = 1'b1;
            if (flush_i)       state_nxt = S_IDLE;
            else if (cnt_zero) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f3_q           <= '0;
         rd_q           <= '0;
         neg_q          <= 1'b0;
         result_valid_o <= 1'b0;
         result_o       <= '0;
         rd_o           <= '0;
      end else begin
         result_valid_o <= 1'b0;
         if (accept) begin
            f3_q  <= funct3_i;
            rd_q  <= rd_i;
            neg_q <= neg_nxt;
            if (fast) begin
               result_valid_o <= 1'b1;
               result_o       <= fast_res;
               rd_o           <= rd_i;
            end
         end else if (busy && cnt_zero && !flush_i) begin
            result_valid_o <= 1'b1;
            result_o       <= fix_res;
            rd_o           <= rd_q;
         end
      end
   end

endmodule
